// File: rtl/key_pkg.sv
// Shared key-input definitions: debouncer and click-decoder state types
// and default timing values for simulation and board builds.
package key_pkg;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_CHECK   = 2'd1,
    DB_PRESSED = 2'd2
  } db_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } click_state_t;

  localparam int unsigned DOUBLE_WIN_SIM   = 2000;
  localparam int unsigned DOUBLE_WIN_BOARD = 5_000_000;
  localparam int unsigned HOLD_TIME_SIM    = 500;
  localparam int unsigned HOLD_TIME_BOARD  = 1_250_000;

endpackage

// File: rtl/key_click_decode.sv
// Classifies debounced press pulses into single/double clicks, with a
// post-double-click hold-off and press/drop statistics.
module key_click_decode
  import key_pkg::*;
#(
  parameter int unsigned DOUBLE_WIN = DOUBLE_WIN_SIM,
  parameter int unsigned HOLD_TIME  = HOLD_TIME_SIM,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pulse,
  output logic       single_click,
  output logic       double_click,
  output logic       busy,
  output logic [7:0] click_cnt,
  output logic [7:0] drop_cnt
);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(DOUBLE_WIN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TIME - 1);

  click_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cyc, w_cyc_nxt;
  logic             r_single, w_single_nxt;
  logic             r_double, w_double_nxt;
  logic [7:0]       r_click, w_click_nxt;
  logic [7:0]       r_drop, w_drop_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cyc    <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_click  <= '0;
      r_drop   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cyc    <= w_cyc_nxt;
      r_single <= w_single_nxt;
      r_double <= w_double_nxt;
      r_click  <= w_click_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_nxt    = r_cyc;
    w_single_nxt = 1'b0;
    w_double_nxt = 1'b0;
    w_click_nxt  = r_click;
    w_drop_nxt   = r_drop;
    case (r_state)
      IDLE: begin
        if (key_pulse) begin
          w_state_nxt = WAIT;
          w_cyc_nxt   = '0;
          w_click_nxt = r_click + 8'd1;
        end
      end
      WAIT: begin
        // A second press on the expiry edge still counts as a double click.
        if (key_pulse) begin
          w_double_nxt = 1'b1;
          w_state_nxt  = HOLD;
          w_cyc_nxt    = '0;
          w_click_nxt  = r_click + 8'd1;
        end else if (r_cyc == WIN_LAST) begin
          w_single_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end
      HOLD: begin
        if (key_pulse && (r_drop != '1)) w_drop_nxt = r_drop + 8'd1;
        if (r_cyc == HOLD_LAST) w_state_nxt = IDLE;
        else                    w_cyc_nxt   = r_cyc + 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cyc_nxt   = '0;
      end
    endcase
  end

  assign single_click = r_single;
  assign double_click = r_double;
  assign busy         = (r_state != IDLE);
  assign click_cnt    = r_click;
  assign drop_cnt     = r_drop;

endmodule

// File: tb/tb_key_click_decode.sv
// Self-checking bench for key_click_decode: directed scenarios plus random
// pulse/reset traffic against a timestamp-based reference model.
module tb_key_click_decode;

  localparam int unsigned DW = 10;
  localparam int unsigned HT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_pulse = 1'b0;
  logic       single_click, double_click, busy;
  logic [7:0] click_cnt, drop_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;

  key_click_decode #(.DOUBLE_WIN(DW), .HOLD_TIME(HT), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse),
    .single_click(single_click), .double_click(double_click), .busy(busy),
    .click_cnt(click_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: remembers when the window opened / hold-off began
  // and compares the current edge number against those deadlines.
  typedef enum {M_IDLE, M_WIN, M_HOLD} mode_t;
  mode_t       m_mode = M_IDLE;
  longint      edge_n = 0;
  longint      t_open = 0;
  longint      t_dbl  = 0;
  logic        e_single = 0, e_double = 0;
  int unsigned e_click = 0, e_drop = 0;
  int unsigned n_single = 0, n_double = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic kp, input logic r);
    edge_n++;
    e_single = 0;
    e_double = 0;
    if (r) begin
      m_mode = M_IDLE; e_click = 0; e_drop = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (kp) begin
          m_mode = M_WIN; t_open = edge_n; e_click = (e_click + 1) % 256;
        end
        M_WIN: if (kp) begin
          e_double = 1; m_mode = M_HOLD; t_dbl = edge_n; e_click = (e_click + 1) % 256;
        end else if (edge_n == t_open + DW) begin
          e_single = 1; m_mode = M_IDLE;
        end
        M_HOLD: begin
          if (kp && e_drop < 255) e_drop++;
          if (edge_n == t_dbl + HT) m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic step(input logic kp, input logic r = 1'b0);
    key_pulse = kp;
    rst = r;
    @(posedge clk);
    model_edge(kp, r);
    #1;
    key_pulse = 1'b0;
    rst = 1'b0;
    if (single_click) n_single++;
    if (double_click) n_double++;
    chk("single_click", 32'(single_click), 32'(e_single));
    chk("double_click", 32'(double_click), 32'(e_double));
    chk("busy",         32'(busy),         32'(m_mode != M_IDLE));
    chk("click_cnt",    32'(click_cnt),    e_click);
    chk("drop_cnt",     32'(drop_cnt),     e_drop);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    n_single = 0;
    n_double = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_click", 32'(click_cnt), 32'd0);

    // Single press: single_click exactly after E10
    step(1'b1);
    idle(9);
    chk("single_not_yet", 32'(single_click), 32'd0);
    idle(1);
    chk("single_at_E10", 32'(single_click), 32'd1);
    idle(3);
    chk("single_count", n_single, 32'd1);
    chk("single_no_dbl", n_double, 32'd0);

    // Presses at E0 and E5
    do_reset();
    step(1'b1); idle(4); step(1'b1);
    chk("dbl_E5", 32'(double_click), 32'd1);
    idle(8);
    chk("dbl_clicks", 32'(click_cnt), 32'd2);
    chk("dbl_no_single", n_single, 32'd0);

    // Boundary: E0 and E10 -> double
    do_reset();
    step(1'b1); idle(9); step(1'b1);
    chk("bnd_dbl", 32'(double_click), 32'd1);
    idle(6);
    chk("bnd_no_single", n_single, 32'd0);

    // E0 and E11 -> single then new sequence
    do_reset();
    step(1'b1); idle(10); step(1'b1);
    chk("bnd_new_seq_busy", 32'(busy), 32'd1);
    chk("bnd_new_seq_click", 32'(click_cnt), 32'd2);
    idle(12);

    // Hold-off: E0,E2,E3,E6,E7
    do_reset();
    step(1'b1); idle(1); step(1'b1); step(1'b1); idle(2); step(1'b1); step(1'b1);
    chk("hold_drop", 32'(drop_cnt), 32'd2);
    chk("hold_click", 32'(click_cnt), 32'd3);
    chk("hold_busy", 32'(busy), 32'd1);
    idle(12);

    // Reset mid-WAIT
    do_reset();
    step(1'b1); idle(3); step(1'b0, 1'b1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    idle(12);
    chk("rst_mid_no_pulse", n_single + n_double, 32'd0);
    step(1'b1); idle(10);
    chk("rst_after_single", n_single, 32'd1);

    // Wrap: 256 single clicks
    do_reset();
    for (int unsigned k = 0; k < 256; k++) begin
      step(1'b1);
      idle(DW);
    end
    chk("wrap_click", 32'(click_cnt), 32'd0);
    chk("wrap_drop", 32'(drop_cnt), 32'd0);
    chk("wrap_singles", n_single, 32'd256);

    // Random traffic with occasional reset
    do_reset();
    for (int unsigned k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 299) == 0));
    end

    // Saturation of drop_cnt: repeated double clicks with dense hold presses
    do_reset();
    for (int unsigned k = 0; k < 70; k++) begin
      step(1'b1); step(1'b1);
      for (int unsigned j = 0; j < HT; j++) step(1'b1);
      idle(1);
    end
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_click_decode.md
# key_click_decode

Downstream stage of the key debouncer: consumes its one-cycle "press accepted" pulse and classifies each press sequence as a single click or a double click. A second press inside a configurable window gives a double click; otherwise the window expiry gives a single click. After a double click, a hold-off period discards further presses. The block also keeps a running count of accepted presses for the display/control logic that sits after it.

## Interface
Parameters:
- DOUBLE_WIN, 2000 — window length in clk cycles in which a second press counts as a double click (simulation value; board value 5_000_000); must be ≥1.
- HOLD_TIME, 500 — clk cycles after a double click during which presses are dropped; must be ≥1.
- CNT_W, 24 — width of the internal cycle counter; DOUBLE_WIN and HOLD_TIME must each be < 2^CNT_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_pulse  in  1  one-cycle press pulse from the debouncer, already synchronous to clk.
- single_click  out  1  one-cycle pulse: a single click was decoded.
- double_click  out  1  one-cycle pulse: a double click was decoded.
- busy  out  1  high whenever the FSM is not in IDLE.
- click_cnt  out  8  count of accepted presses; wraps 255→0.
- drop_cnt  out  8  count of presses dropped in HOLD; saturates at 255.

## Operation
States: IDLE, WAIT, HOLD. One shared counter `cyc` (CNT_W bits) is used for both the window and the hold-off.

- IDLE: on key_pulse → WAIT, cyc←0, click_cnt+1.
- WAIT: on each edge, the checks below are applied in this priority order:
  - key_pulse → double_click←1, state→HOLD, cyc←0, click_cnt+1.
  - else if cyc==DOUBLE_WIN-1 → single_click←1, state→IDLE.
  - else cyc+1.
- HOLD:
  - key_pulse → drop_cnt+1 (saturating), no other effect.
  - if cyc==HOLD_TIME-1 → state→IDLE; else cyc+1.
  - A pulse on that exit edge is dropped and counted.
- single_click and double_click are registered and default to 0 every cycle. They are never high together.
- busy is decoded from the state register (state≠IDLE).
- Reset (any cycle, including mid-WAIT or mid-HOLD): state=IDLE, cyc=0, single_click=0, double_click=0, busy=0, click_cnt=0, drop_cnt=0. A press sequence in progress is discarded with no output pulse.
- Illegal state encoding → IDLE on the next edge.

## Timing
- The first press is sampled at edge E0. A second pulse sampled at edges E1…E_DOUBLE_WIN gives a double click.
- double_click is high in the cycle after the edge that sampled the second pulse.
- With no second pulse, single_click is high in the cycle after edge E_DOUBLE_WIN, so single-click latency is exactly DOUBLE_WIN cycles from E0.
- Boundary: a second pulse at edge E_DOUBLE_WIN (cyc==DOUBLE_WIN-1) wins over expiry and gives a double click with no single click.
- Pulses are back-to-back legal: a pulse at E0 followed by one at E1 gives a double click.
- After a double click at edge Ed, HOLD lasts HOLD_TIME cycles. The block is back in IDLE after edge Ed+HOLD_TIME, and the first new press is accepted at edge Ed+HOLD_TIME+1.
- A new press in the same cycle that single_click is asserted (state already IDLE) is accepted and starts a new WAIT.

## Structure
- Shared package key_pkg holds:
  - the state enum/localparams (IDLE, WAIT, HOLD), alongside the debouncer's state constants;
  - the default DOUBLE_WIN and HOLD_TIME values for simulation and board builds.
- No sub-module: the single counter, the FSM and the two 8-bit statistics counters fit in one module.

## Test plan
All scenarios use DOUBLE_WIN=10, HOLD_TIME=4.
- Single press at E0, no further pulses → single_click high exactly in the cycle after E10; double_click never high; click_cnt=1; busy high E1–E10.
- Presses at E0 and E5 → double_click high after E5; no single_click; click_cnt=2; busy drops after E9.
- Boundary: presses at E0 and E10 → double_click; presses at E0 and E11 → single_click after E10, then a new sequence starting at E11 (click_cnt=2).
- Hold-off: presses at E0, E2, E3, E6, E7 → double_click after E2; the E3 and E6 pulses are dropped (drop_cnt=2); E7 is accepted and starts WAIT (click_cnt=3).
- Reset: press at E0, rst high at E4 → all outputs 0 at E5; no click pulse ever emitted; a later press after rst low is decoded normally.
- Wrap: 256 single-click sequences → click_cnt returns to 0 and drop_cnt stays 0.
